// File: rtl/tmr_majority_voter.sv
// Registered bitwise 2-of-3 majority voter with replica disagreement flags.
// Define TMR_VOTER_STATS_EN to add saturating per-replica disagreement counters.
module tmr_majority_voter #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] M,
  output logic             out_valid,
  output logic             mismatch,
  output logic [1:0]       fault_id,
  output logic             multi_fault,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);

  logic [WIDTH-1:0] vote;
  logic             d_a;
  logic             d_b;
  logic             d_c;
  logic [1:0]       fault_id_next;
  logic             multi_fault_next;

  logic [WIDTH-1:0] m_reg;
  logic             out_valid_reg;
  logic             mismatch_reg;
  logic [1:0]       fault_id_reg;
  logic             multi_fault_reg;

  always_comb begin
    vote = (A & B) | (A & C) | (B & C);
    d_a  = |(A ^ vote);
    d_b  = |(B ^ vote);
    d_c  = |(C ^ vote);
    // Two or more dissenters is only possible when they dissent on different bits.
    multi_fault_next = (d_a & d_b) | (d_a & d_c) | (d_b & d_c);
    fault_id_next    = 2'd0;
    case ({d_a, d_b, d_c})
      3'b100:  fault_id_next = 2'd1;
      3'b010:  fault_id_next = 2'd2;
      3'b001:  fault_id_next = 2'd3;
      default: fault_id_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg           <= '0;
      out_valid_reg   <= 1'b0;
      mismatch_reg    <= 1'b0;
      fault_id_reg    <= 2'd0;
      multi_fault_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      // Result fields hold across invalid cycles so the consumer sees the last vote.
      if (in_valid) begin
        m_reg           <= vote;
        mismatch_reg    <= d_a | d_b | d_c;
        fault_id_reg    <= fault_id_next;
        multi_fault_reg <= multi_fault_next;
      end
    end
  end

  assign M           = m_reg;
  assign out_valid   = out_valid_reg;
  assign mismatch    = mismatch_reg;
  assign fault_id    = fault_id_reg;
  assign multi_fault = multi_fault_reg;

`ifdef TMR_VOTER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [2:0] hit;
  assign hit = {d_c, d_b, d_a};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
        cnt_reg <= '0;
      end else if (in_valid && hit[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign cnt_a = g_cnt[0].cnt_reg;
  assign cnt_b = g_cnt[1].cnt_reg;
  assign cnt_c = g_cnt[2].cnt_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_a = '0;
  assign cnt_b = '0;
  assign cnt_c = '0;
`endif

endmodule

// File: tb/tb_tmr_majority_voter.sv
// Directed-vector bench for tmr_majority_voter: 1-bit truth table, 8-bit flags,
// hold/reset behaviour and (when built with TMR_VOTER_STATS_EN) counter saturation.
module tb_tmr_majority_voter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // 1-bit instance
  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       m1, ov1, mm1, mf1;
  logic [1:0] fid1;
  logic [15:0] ca1, cb1, cc1;

  // 8-bit instance
  logic       v8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, c8 = '0, m8;
  logic       ov8, mm8, mf8;
  logic [1:0] fid8;
  logic [15:0] ca8, cb8, cc8;

  // 4-bit instance with 2-bit counters
  logic       vs = 1'b0, clr_s = 1'b0;
  logic [3:0] as_ = '0, bs = '0, cs = '0, ms;
  logic       ovs, mms, mfs;
  logic [1:0] fids;
  logic [1:0] cas, cbs, ccs;

  tmr_majority_voter #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .C(c1),
    .M(m1), .out_valid(ov1), .mismatch(mm1), .fault_id(fid1), .multi_fault(mf1),
    .cnt_clr(1'b0), .cnt_a(ca1), .cnt_b(cb1), .cnt_c(cc1)
  );

  tmr_majority_voter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .C(c8),
    .M(m8), .out_valid(ov8), .mismatch(mm8), .fault_id(fid8), .multi_fault(mf8),
    .cnt_clr(1'b0), .cnt_a(ca8), .cnt_b(cb8), .cnt_c(cc8)
  );

  tmr_majority_voter #(.WIDTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(vs), .A(as_), .B(bs), .C(cs),
    .M(ms), .out_valid(ovs), .mismatch(mms), .fault_id(fids), .multi_fault(mfs),
    .cnt_clr(clr_s), .cnt_a(cas), .cnt_b(cbs), .cnt_c(ccs)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] em, input logic eov,
                      input logic emm, input logic [1:0] efid, input logic emf);
    n_vec++;
    $display("%s: A=%h B=%h C=%h -> M=%h ov=%b mm=%b fid=%0d mf=%b",
             name, a8, b8, c8, m8, ov8, mm8, fid8, mf8);
    if ({m8, ov8, mm8, fid8, mf8} !== {em, eov, emm, efid, emf}) begin
      n_err++;
      $display("FAIL %s: got M=%h ov=%b mm=%b fid=%0d mf=%b, want M=%h ov=%b mm=%b fid=%0d mf=%b",
               name, m8, ov8, mm8, fid8, mf8, em, eov, emm, efid, emf);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    v1 = 1'b1; v8 = 1'b1; vs = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    tick;
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0; vs = 1'b0;
    chk8("reset_dut8", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    n_vec++;
    $display("reset_dut1: M=%b ov=%b mm=%b fid=%0d mf=%b", m1, ov1, mm1, fid1, mf1);
    if ({m1, ov1, mm1, fid1, mf1} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_dut1: got %b, want 000000", {m1, ov1, mm1, fid1, mf1});
    end
    n_vec++;
    $display("reset_dut_s: M=%h ov=%b cnt=%0d/%0d/%0d", ms, ovs, cas, cbs, ccs);
    if ({ms, ovs, mms, fids, mfs, cas, cbs, ccs} !== 15'b0) begin
      n_err++;
      $display("FAIL reset_dut_s: got M=%h ov=%b cnt=%0d/%0d/%0d, want all 0",
               ms, ovs, cas, cbs, ccs);
    end
  endtask

  task automatic test_truth_table;
    logic [7:0] m_tab  = 8'hE8;  // ABC=000..111 -> 0,0,0,1,0,1,1,1
    int         fid_tab[8] = '{0, 3, 2, 1, 1, 2, 3, 0};
    logic [2:0] abc;
    logic       emm;
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      {a1, b1, c1} = abc;
      v1 = 1'b1;
      tick;
      emm = (fid_tab[i] != 0);
      n_vec++;
      $display("truth ABC=%b -> M=%b ov=%b mm=%b fid=%0d mf=%b", abc, m1, ov1, mm1, fid1, mf1);
      if ({m1, ov1, mm1, fid1, mf1} !== {m_tab[i], 1'b1, emm, fid_tab[i][1:0], 1'b0}) begin
        n_err++;
        $display("FAIL truth_%b: got M=%b ov=%b mm=%b fid=%0d mf=%b, want M=%b ov=1 mm=%b fid=%0d mf=0",
                 abc, m1, ov1, mm1, fid1, mf1, m_tab[i], emm, fid_tab[i]);
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_fault_id;
    v8 = 1'b1;
    a8 = 8'h5A; b8 = 8'h5A; c8 = 8'h5A; tick;
    chk8("agree_5A", 8'h5A, 1'b1, 1'b0, 2'd0, 1'b0);
    a8 = 8'hFF; tick;
    chk8("fault_A", 8'h5A, 1'b1, 1'b1, 2'd1, 1'b0);
    a8 = 8'h5A; b8 = 8'h5B; tick;
    chk8("fault_B", 8'h5A, 1'b1, 1'b1, 2'd2, 1'b0);
    b8 = 8'h5A; c8 = 8'hA5; tick;
    chk8("fault_C", 8'h5A, 1'b1, 1'b1, 2'd3, 1'b0);
    v8 = 1'b0;
  endtask

  task automatic test_multi_fault;
    v8 = 1'b1;
    a8 = 8'h01; b8 = 8'h02; c8 = 8'h00; tick;
    chk8("multi_AB", 8'h00, 1'b1, 1'b1, 2'd0, 1'b1);
    a8 = 8'hF0; b8 = 8'h0F; c8 = 8'h3C; tick;
    chk8("multi_ABC", 8'h3C, 1'b1, 1'b1, 2'd0, 1'b1);
    v8 = 1'b0;
  endtask

  task automatic test_hold_and_reset;
    v8 = 1'b1; a8 = 8'hC3; b8 = 8'hC3; c8 = 8'h00; tick;
    chk8("hold_load", 8'hC3, 1'b1, 1'b1, 2'd3, 1'b0);
    v8 = 1'b0; a8 = 8'h00; b8 = 8'hFF; c8 = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk8($sformatf("hold_%0d", i), 8'hC3, 1'b0, 1'b1, 2'd3, 1'b0);
    end
    rst = 1'b1; v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 8'h0F; tick;
    rst = 1'b0;
    chk8("midstream_reset", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    tick;
    chk8("first_after_reset", 8'hFF, 1'b1, 1'b1, 2'd3, 1'b0);
    v8 = 1'b0;
  endtask

  task automatic test_stats;
    logic [1:0] exp_b;
    vs = 1'b1; as_ = 4'h0; bs = 4'h4; cs = 4'h0; clr_s = 1'b0;
    for (int i = 0; i < 7; i++) begin
      // i 0..4: B faulty; 5: clear without fault; 6: clear with fault
      if (i == 5) begin clr_s = 1'b1; bs = 4'h0; end
      if (i == 6) bs = 4'h4;
      tick;
`ifdef TMR_VOTER_STATS_EN
      exp_b = (i >= 5) ? 2'd0 : ((i >= 2) ? 2'd3 : 2'(i + 1));
`else
      exp_b = 2'd0;
`endif
      n_vec++;
      $display("stats_%0d: B=%h clr=%b -> M=%h cnt=%0d/%0d/%0d", i, bs, clr_s, ms, cas, cbs, ccs);
      if ({ms, cas, cbs, ccs} !== {4'h0, 2'd0, exp_b, 2'd0}) begin
        n_err++;
        $display("FAIL stats_%0d: got M=%h cnt=%0d/%0d/%0d, want M=0 cnt=0/%0d/0",
                 i, ms, cas, cbs, ccs, exp_b);
      end
    end
    clr_s = 1'b0; tick;
`ifdef TMR_VOTER_STATS_EN
    exp_b = 2'd1;
`else
    exp_b = 2'd0;
`endif
    n_vec++;
    $display("stats_after_clr: cnt_b=%0d fid=%0d", cbs, fids);
    if ({cbs, fids} !== {exp_b, 2'd2}) begin
      n_err++;
      $display("FAIL stats_after_clr: got cnt_b=%0d fid=%0d, want cnt_b=%0d fid=2", cbs, fids, exp_b);
    end
    vs = 1'b0;
  endtask

  initial begin
    test_reset;
    test_truth_table;
    test_fault_id;
    test_multi_fault;
    test_hold_and_reset;
    test_stats;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
